// File: rtl/pdm_cic_decimator.sv
// Third-order CIC decimator turning a strobed 1-bit PDM stream into signed PCM samples.
// Output appears 4 cycles after each decimation event; an unconsumed sample is overwritten and flagged.
module pdm_cic_decimator #(
  parameter int DECIM    = 16,
  parameter int OUT_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pdm_en,
  input  logic                       pdm_bit,
  output logic signed [OUT_BITS-1:0] out_sample,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overrun
);

  localparam int LOG2 = $clog2(DECIM);
  localparam int W    = 1 + 3 * LOG2;
  localparam int WP   = W + 1;
  localparam int SH   = W - 1 - OUT_BITS;
  localparam logic signed [W:0] OFFSET = WP'(1) << (W - 2);
  localparam logic signed [W:0] QMAX   = WP'(1) << (OUT_BITS - 1);

  logic [W-1:0]    integ1, integ2, integ3;
  logic [W-1:0]    dly1, dly2, dly3;
  logic [W-1:0]    comb1, comb2, comb3;
  logic [LOG2-1:0] dec_cnt;
  logic            vld1, vld2, vld3;
  logic [1:0]      warm;
  logic            dec_evt;

  logic signed [W:0]          centred;
  logic signed [W:0]          shifted;
  logic signed [OUT_BITS-1:0] fmt;

  // DECIM is a power of two, so the last count of the window is all ones
  assign dec_evt = pdm_en & (&dec_cnt);

  assign centred = $signed({1'b0, comb3}) - OFFSET;
  assign shifted = centred >>> SH;

  always_comb begin
    fmt = shifted[OUT_BITS-1:0];
    // Only a full-scale positive input can land one step above the top code
    if (shifted == QMAX) fmt = {1'b0, {(OUT_BITS-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      integ1     <= '0;
      integ2     <= '0;
      integ3     <= '0;
      dly1       <= '0;
      dly2       <= '0;
      dly3       <= '0;
      comb1      <= '0;
      comb2      <= '0;
      comb3      <= '0;
      dec_cnt    <= '0;
      vld1       <= 1'b0;
      vld2       <= 1'b0;
      vld3       <= 1'b0;
      warm       <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (pdm_en) begin
        integ1  <= integ1 + {{(W-1){1'b0}}, pdm_bit};
        integ2  <= integ2 + integ1;
        integ3  <= integ3 + integ2;
        dec_cnt <= dec_cnt + LOG2'(1);
      end

      vld1 <= dec_evt;
      vld2 <= vld1;
      vld3 <= vld2;

      if (dec_evt) begin
        comb1 <= integ3 - dly1;
        dly1  <= integ3;
      end
      if (vld1) begin
        comb2 <= comb1 - dly2;
        dly2  <= comb1;
      end
      if (vld2) begin
        comb3 <= comb2 - dly3;
        dly3  <= comb2;
      end

      // The first two results still carry the zeroed comb history and are dropped
      if (vld3 && warm != 2'd2) begin
        warm <= warm + 2'd1;
      end else if (vld3) begin
        out_sample <= fmt;
        out_valid  <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pdm_cic_decimator.md
PDM_CIC_DECIMATOR -- requirements
Module: pdm_cic_decimator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DECIM, default 16, SHALL set the decimation ratio; legal values are 8, 16, 32 and 64.
REQ-003 Parameter OUT_BITS, default 8, SHALL set the output sample width; legal values are 4 to 8.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous active-high reset.
REQ-006 pdm_en  input  1  SHALL be a one-cycle strobe marking a valid PDM bit; it comes from the sample-rate divider.
REQ-007 pdm_bit  input  1  SHALL be the PDM data bit, sampled only when pdm_en=1.
REQ-008 out_sample  output  OUT_BITS  SHALL carry the signed two's-complement PCM sample.
REQ-009 out_valid  output  1  SHALL be high while out_sample holds an unconsumed sample.
REQ-010 out_ready  input  1  SHALL be the downstream acceptance; a transfer occurs when out_valid and out_ready are both high.
REQ-011 overrun  output  1  SHALL be a sticky flag: an unconsumed sample was overwritten.

Function
REQ-012 Internal width W SHALL be 1+3*log2(DECIM), which is 13 for the default; all integrator and comb arithmetic is unsigned modulo 2^W.
REQ-013 The filter SHALL be a 3rd-order CIC: three cascaded integrators, then a decimate-by-DECIM step, then three cascaded combs with differential delay 1.
REQ-014 On each pdm_en cycle, integrator 1 SHALL add pdm_bit (0 or 1), and integrators 2 and 3 SHALL add the previous stage's registered value; integrators SHALL hold when pdm_en=0.
REQ-015 A decimation counter SHALL count pdm_en pulses from 0 to DECIM-1 and then wrap to 0.
REQ-016 The pdm_en cycle in which the counter reaches DECIM-1 SHALL be a decimation event that captures integrator 3 into the comb pipeline.
REQ-017 The comb pipeline SHALL use one register stage per comb plus one output-formatting stage.
REQ-018 out_valid SHALL rise exactly 4 clk cycles after the decimation-event cycle; the latency is fixed and independent of later pdm_en activity.
REQ-019 Formatting: c = comb3 output, read as unsigned 0..2^(W-1); centred value s = c - 2^(W-2).
REQ-020 Formatting: q = s arithmetically shifted right by (W-1-OUT_BITS), which floors toward minus infinity.
REQ-021 Formatting: q = +2^(OUT_BITS-1) SHALL saturate to 2^(OUT_BITS-1)-1; no other clipping occurs.
REQ-022 Warm-up: the first 2 decimated results after reset SHALL be discarded without asserting out_valid; the 3rd and all later results SHALL be presented.
REQ-023 Holding: while out_valid=1 and out_ready=0, out_sample SHALL remain stable.
REQ-024 A transfer (out_valid=1 and out_ready=1) with no new sample arriving in the same cycle SHALL clear out_valid on the next cycle.
REQ-025 If a new sample arrives while out_valid=1 and out_ready=0, it SHALL overwrite out_sample, out_valid SHALL stay 1, and overrun SHALL set.
REQ-026 If a new sample arrives in the same cycle as a transfer, the new sample SHALL load, out_valid SHALL stay 1, and overrun SHALL be unaffected.
REQ-027 overrun SHALL remain set until reset.
REQ-028 pdm_en pulses MAY arrive on consecutive cycles; the minimum decimation-event spacing of DECIM cycles guarantees the comb pipeline never overlaps.
REQ-029 pdm_bit SHALL be ignored on cycles where pdm_en=0.

Reset
REQ-030 While rst=1 at a clock edge, all integrators, comb delays, pipeline registers, the decimation counter and the warm-up counter SHALL clear to 0.
REQ-031 During reset, out_sample SHALL be 0, out_valid SHALL be 0 and overrun SHALL be 0.
REQ-032 pdm_en SHALL be ignored while rst=1.
REQ-033 Reset asserted mid-window or mid-pipeline SHALL discard all in-flight data, and warm-up SHALL restart from zero.

Verification
REQ-034 Default parameters, out_ready=1, pdm_bit=1 on every pdm_en: the first out_valid SHALL occur 4 cycles after the 48th pdm_en pulse with out_sample=127 (saturated), and every subsequent sample SHALL be 127.
REQ-035 pdm_bit=0 constant: settled out_sample SHALL be -128 (0x80).
REQ-036 pdm_bit alternating 1,0,1,0 from reset: settled out_sample SHALL be 0.
REQ-037 out_ready=0 across two decimation events: out_sample SHALL equal the second result, out_valid SHALL be 1 and overrun SHALL be 1; raising out_ready for one cycle SHALL clear out_valid, with overrun still 1.
REQ-038 Reset asserted for one cycle midway through the 30th pdm_en window: out_valid SHALL be 0 next cycle, and the first new out_valid SHALL occur only after 48 further pdm_en pulses plus 4 cycles.
REQ-039 DECIM=8, OUT_BITS=8, all-ones input: the first valid SHALL follow the 24th pdm_en pulse plus 4 cycles with out_sample=127; pdm_en held low SHALL produce no out_valid.
